bcd_compare_seq: RTL and testbench



---
 rtl/bcd_compare_seq.sv | 167 ++++++++++++++++
 tb/tb_bcd_compare_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_compare_seq.sv
// bcd_compare_seq
//   Sequential magnitude comparator for two unsigned packed-BCD operands of
//   DIGITS digits. Operands are latched on start and scanned one digit per
//   clock from the most significant digit down. The scan stops at the first
//   differing digit, or at digit 0 when all digits match. A non-BCD nibble
//   (value > 9) in either operand ends the scan after one cycle with only
//   'invalid' set.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start_i    request, sampled only while idle (busy_o = 0)
//   a_i, b_i   packed BCD operands, digit DIGITS-1 in the top nibble
//   busy_o     comparison in progress
//   done_o     one-cycle pulse; flags are valid from this cycle on
//   a_gt_b_o   A >  B
//   a_eq_b_o   A == B
//   a_lt_b_o   A <  B
//   a_ge_b_o   A >= B
//   invalid_o  a nibble of A or B was greater than 9
//
// State table
//   IDLE | waiting for start; result flags hold the last outcome
//   SCAN | comparing digit idx of the latched operands
module bcd_compare_seq #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [4*DIGITS-1:0]   a_i,
  input  logic [4*DIGITS-1:0]   b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  a_gt_b_o,
  output logic                  a_eq_b_o,
  output logic                  a_lt_b_o,
  output logic                  a_ge_b_o,
  output logic                  invalid_o
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic               inv_q;
  logic [IDX_W-1:0]   idx_q;
  logic               busy_q;
  logic               done_q;
  logic               gt_q;
  logic               eq_q;
  logic               lt_q;
  logic               ge_q;
  logic               invalid_q;

  logic [3:0]         dig_a;
  logic [3:0]         dig_b;
  logic               inv_in;

  function automatic logic has_non_bcd(input logic [W-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | (v[i*4 +: 4] > 4'd9);
    end
    return r;
  endfunction

  assign inv_in = has_non_bcd(a_i) | has_non_bcd(b_i);

  // idx_q never exceeds DIGITS-1, so the slice stays inside the operand.
  assign dig_a = a_q[{idx_q, 2'b00} +: 4];
  assign dig_b = b_q[{idx_q, 2'b00} +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      inv_q     <= 1'b0;
      idx_q     <= IDX_TOP;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      ge_q      <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            inv_q   <= inv_in;
            idx_q   <= IDX_TOP;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (inv_q) begin
            invalid_q <= 1'b1;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            ge_q      <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (dig_a > dig_b) begin
            invalid_q <= 1'b0;
            gt_q      <= 1'b1;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            ge_q      <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (dig_a < dig_b) begin
            invalid_q <= 1'b0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b1;
            ge_q      <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (idx_q == '0) begin
            invalid_q <= 1'b0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b1;
            lt_q      <= 1'b0;
            ge_q      <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign a_gt_b_o  = gt_q;
  assign a_eq_b_o  = eq_q;
  assign a_lt_b_o  = lt_q;
  assign a_ge_b_o  = ge_q;
  assign invalid_o = invalid_q;

endmodule

// File: tb/tb_bcd_compare_seq.sv
// Testbench for bcd_compare_seq: three instances (DIGITS = 4, 1, 8) share a
// clock, reset and operand bus; each has its own start. Results are checked
// against a decimal reference model.
module tb_bcd_compare_seq;

  logic        clk;
  logic        rst;
  logic [2:0]  start_v;
  logic [63:0] a_s;
  logic [63:0] b_s;
  logic [2:0]  busy_w, done_w, gt_w, eq_w, lt_w, ge_w, inv_w;

  int n_cmp;
  int n_bad;
  logic [4:0] prev_f [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bcd_compare_seq #(.DIGITS(4)) u_d4 (
    .clk(clk), .rst(rst), .start_i(start_v[0]),
    .a_i(a_s[15:0]), .b_i(b_s[15:0]),
    .busy_o(busy_w[0]), .done_o(done_w[0]),
    .a_gt_b_o(gt_w[0]), .a_eq_b_o(eq_w[0]), .a_lt_b_o(lt_w[0]),
    .a_ge_b_o(ge_w[0]), .invalid_o(inv_w[0])
  );

  bcd_compare_seq #(.DIGITS(1)) u_d1 (
    .clk(clk), .rst(rst), .start_i(start_v[1]),
    .a_i(a_s[3:0]), .b_i(b_s[3:0]),
    .busy_o(busy_w[1]), .done_o(done_w[1]),
    .a_gt_b_o(gt_w[1]), .a_eq_b_o(eq_w[1]), .a_lt_b_o(lt_w[1]),
    .a_ge_b_o(ge_w[1]), .invalid_o(inv_w[1])
  );

  bcd_compare_seq #(.DIGITS(8)) u_d8 (
    .clk(clk), .rst(rst), .start_i(start_v[2]),
    .a_i(a_s[31:0]), .b_i(b_s[31:0]),
    .busy_o(busy_w[2]), .done_o(done_w[2]),
    .a_gt_b_o(gt_w[2]), .a_eq_b_o(eq_w[2]), .a_lt_b_o(lt_w[2]),
    .a_ge_b_o(ge_w[2]), .invalid_o(inv_w[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] flags_of(input int s);
    return {gt_w[s], eq_w[s], lt_w[s], ge_w[s], inv_w[s]};
  endfunction

  function automatic int digit_of(input logic [63:0] v, input int i);
    logic [63:0] t;
    t = (v >> (4 * i)) & 64'hF;
    return int'(t[3:0]);
  endfunction

  // Flags are {gt, eq, lt, ge, invalid}; m is the number of digits examined.
  task automatic ref_eval(input int n, input logic [63:0] a, input logic [63:0] b,
                          output logic [4:0] f, output int m);
    bit     inv;
    bit     found;
    longint va, vb;
    inv = 0; va = 0; vb = 0;
    for (int i = n - 1; i >= 0; i--) begin
      if (digit_of(a, i) > 9 || digit_of(b, i) > 9) inv = 1;
      va = va * 10 + digit_of(a, i);
      vb = vb * 10 + digit_of(b, i);
    end
    if (inv) begin
      f = 5'b00001;
      m = 1;
    end else begin
      if (va > vb)       f = 5'b10010;
      else if (va == vb) f = 5'b01010;
      else               f = 5'b00100;
      m = n;
      found = 0;
      for (int i = n - 1; i >= 0; i--) begin
        if (!found && digit_of(a, i) != digit_of(b, i)) begin
          m = n - i;
          found = 1;
        end
      end
    end
  endtask

  task automatic run_cmp(input int s, input int n, input logic [63:0] a,
                         input logic [63:0] b, input bit disturb);
    logic [4:0] f;
    int         m;
    bit         got;
    ref_eval(n, a, b, f, m);
    @(negedge clk);
    a_s = a;
    b_s = b;
    start_v[s] = 1'b1;
    @(posedge clk);
    #1;
    start_v[s] = 1'b0;
    chk("busy_after_accept", {31'd0, busy_w[s]}, 32'd1);
    if (disturb) begin
      a_s = 64'h9999_9999;
      start_v[s] = 1'b1;
    end
    got = 0;
    for (int c = 1; c <= n + 2; c++) begin
      @(posedge clk);
      #1;
      start_v[s] = 1'b0;
      if (done_w[s]) begin
        chk("latency", c, m);
        chk("flags", {27'd0, flags_of(s)}, {27'd0, f});
        chk("busy_at_done", {31'd0, busy_w[s]}, 32'd0);
        prev_f[s] = f;
        got = 1;
        break;
      end else begin
        chk("flags_hold", {27'd0, flags_of(s)}, {27'd0, prev_f[s]});
      end
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [63:0] ra, rb;
    bit          same;
    int          da, db;

    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    start_v = '0;
    a_s = '0;
    b_s = '0;
    for (int s = 0; s < 3; s++) prev_f[s] = 5'b0;

    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("reset_busy",  {31'd0, busy_w[s]}, 32'd0);
      chk("reset_done",  {31'd0, done_w[s]}, 32'd0);
      chk("reset_flags", {27'd0, flags_of(s)}, 32'd0);
    end
    rst = 1'b0;

    // Directed DIGITS=4 cases
    run_cmp(0, 4, 64'h1234, 64'h1234, 0);
    run_cmp(0, 4, 64'h9000, 64'h8999, 0);
    run_cmp(0, 4, 64'h1233, 64'h1234, 0);   // started in the done cycle
    run_cmp(0, 4, 64'h12A4, 64'h0000, 0);
    run_cmp(0, 4, 64'h0001, 64'h0000, 0);
    run_cmp(0, 4, 64'h5550, 64'h5551, 1);   // operand change + start while busy

    // Reset in the middle of a scan
    @(negedge clk);
    a_s = 64'h0000;
    b_s = 64'h0001;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midscan_rst_busy",  {31'd0, busy_w[0]}, 32'd0);
    chk("midscan_rst_done",  {31'd0, done_w[0]}, 32'd0);
    chk("midscan_rst_flags", {27'd0, flags_of(0)}, 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_no_done", {31'd0, done_w[0]}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) prev_f[s] = 5'b0;
    run_cmp(0, 4, 64'h4321, 64'h4321, 0);
    run_cmp(0, 4, 64'h0700, 64'h0699, 0);

    // DIGITS=1 exhaustive, including non-BCD nibbles
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_cmp(1, 1, 64'(a), 64'(b), 0);
      end
    end

    // DIGITS=8 random, biased toward shared prefixes for long scans
    for (int k = 0; k < 150; k++) begin
      ra = '0;
      rb = '0;
      same = 1;
      for (int i = 7; i >= 0; i--) begin
        da = int'($urandom_range(0, 9));
        if (same && $urandom_range(0, 3) != 0) db = da;
        else db = int'($urandom_range(0, 9));
        if (db != da) same = 0;
        if ($urandom_range(0, 39) == 0) da = int'($urandom_range(10, 15));
        ra = ra | (64'(da) << (4 * i));
        rb = rb | (64'(db) << (4 * i));
      end
      run_cmp(2, 8, ra, rb, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
